// File: rtl/andor_pkg.sv
// Shared constants and helpers for the andor input-conditioning path.
// Latency: none (package only).
// Backpressure: none (package only).
package andor_pkg;

  // Default channel count for the board switch bank.
  localparam int N_SW_DEFAULT = 2;

  // 10 ms of stability at the 50 MHz fabric clock.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  // Width of a counter that must hold values 0..cycles.
  // Clamped to at least 1 bit so a degenerate setting still elaborates.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// Single switch channel: 2-flop synchroniser, stability counter, level register,
// optional rise/fall pulse registers (enabled by SW_DEBOUNCE_EDGE_EN).
// Latency: 2 sync edges + DEBOUNCE_CYCLES compare edges; no backpressure, free-running.
module sw_debounce_ch
  import andor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_in,
  output logic sw_db,
  output logic sw_rise,
  output logic sw_fall
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  // Last count value before the level is allowed to follow the input.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             db_q;
  logic             db_d;

  // Two-stage synchroniser; nothing sits between the stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sw_in;
      s2_q <= s1_q;
    end
  end

  // Count consecutive mismatching cycles; any matching cycle restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter and debounced level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign sw_db = db_q;

`ifdef SW_DEBOUNCE_EDGE_EN
  logic rise_q;
  logic fall_q;

  // Edge pulses land in the same cycle the new level becomes visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= db_d & ~db_q;
      fall_q <= ~db_d & db_q;
    end
  end

  assign sw_rise = rise_q;
  assign sw_fall = fall_q;
`else
  // Edge detection disabled: ports kept so the top level does not change.
  assign sw_rise = 1'b0;
  assign sw_fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Debounce bank for board switches: N_SW independent sw_debounce_ch channels.
// Latency: 2 + DEBOUNCE_CYCLES clocks per channel; pulses need SW_DEBOUNCE_EDGE_EN.
// Backpressure: none, outputs are free-running registered levels/pulses.
module sw_debounce
  import andor_pkg::*;
#(
  parameter int N_SW            = N_SW_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_in,
  output logic [N_SW-1:0] sw_db,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall
);

  // One fully independent channel per switch; no shared counter.
  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    sw_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw_in  (sw_in[i]),
      .sw_db  (sw_db[i]),
      .sw_rise(sw_rise[i]),
      .sw_fall(sw_fall[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with N_SW=2, DEBOUNCE_CYCLES=4.
// Table vectors, hand-written corner sequences, and random stimulus vs a window model.
// Pulse expectations are masked to zero when SW_DEBOUNCE_EDGE_EN is not defined.
module tb_sw_debounce;

  localparam int D = 4;
`ifdef SW_DEBOUNCE_EDGE_EN
  localparam logic EDGE = 1'b1;
`else
  localparam logic EDGE = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sw_in = 2'b00;
  logic [1:0] sw_db;
  logic [1:0] sw_rise;
  logic [1:0] sw_fall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sw_debounce #(
    .N_SW           (2),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_in  (sw_in),
    .sw_db  (sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
  );

  typedef struct {
    logic [1:0] in;
    logic [1:0] db;
    logic [1:0] rise;
    logic [1:0] fall;
  } vec_t;

  vec_t tbl[26];

  // Reference model: the level flips at compare edge k when the last D synchronised
  // samples all disagree with it and all came after its previous flip.
  logic [1:0] inq[$];
  logic [1:0] sq[$];
  int         last_chg[2];
  logic [1:0] mdb;
  logic [1:0] mrise;
  logic [1:0] mfall;

  task automatic model_clear();
    inq.delete();
    sq.delete();
    last_chg[0] = -1;
    last_chg[1] = -1;
    mdb   = 2'b00;
    mrise = 2'b00;
    mfall = 2'b00;
  endtask

  task automatic model_edge(input logic [1:0] v);
    logic [1:0] s2;
    logic [1:0] h;
    int         k;
    bit         ok;
    inq.push_back(v);
    s2 = (inq.size() >= 3) ? inq[inq.size()-3] : 2'b00;
    sq.push_back(s2);
    k = sq.size() - 1;
    mrise = 2'b00;
    mfall = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      ok = (k - last_chg[ch] >= D);
      if (ok) begin
        for (int j = 0; j < D; j++) begin
          h = sq[k-j];
          if (h[ch] == mdb[ch]) ok = 1'b0;
        end
      end
      if (ok) begin
        if (mdb[ch]) mfall[ch] = 1'b1;
        else         mrise[ch] = 1'b1;
        mdb[ch]      = ~mdb[ch];
        last_chg[ch] = k;
      end
    end
  endtask

  task automatic chk(input string name, input logic [1:0] db,
                     input logic [1:0] rise, input logic [1:0] fall);
    logic [1:0] er;
    logic [1:0] ef;
    er = rise & {2{EDGE}};
    ef = fall & {2{EDGE}};
    total++;
    if ({sw_db, sw_rise, sw_fall} !== {db, er, ef}) begin
      bad++;
      $display("FAIL %s t=%0t: got db=%b rise=%b fall=%b, want db=%b rise=%b fall=%b",
               name, $time, sw_db, sw_rise, sw_fall, db, er, ef);
    end
  endtask

  // Drive one input value for one edge, then settle at the falling edge.
  task automatic cyc(input logic [1:0] v);
    sw_in = v;
    @(posedge clk);
    model_edge(v);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] v);
    @(negedge clk);
    rst_n = 1'b0;
    sw_in = v;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    logic [1:0] v;
    int         len;
    int         n;

    // Scenario 2, then a 3-cycle and a 4-cycle pulse on channel 1.
    for (int i = 0; i < 5; i++) tbl[i] = '{2'b01, 2'b00, 2'b00, 2'b00};
    tbl[5]  = '{2'b01, 2'b01, 2'b01, 2'b00};
    tbl[6]  = '{2'b01, 2'b01, 2'b00, 2'b00};
    tbl[7]  = '{2'b01, 2'b01, 2'b00, 2'b00};
    for (int i = 8;  i < 11; i++) tbl[i] = '{2'b11, 2'b01, 2'b00, 2'b00};
    for (int i = 11; i < 15; i++) tbl[i] = '{2'b01, 2'b01, 2'b00, 2'b00};
    for (int i = 15; i < 19; i++) tbl[i] = '{2'b11, 2'b01, 2'b00, 2'b00};
    tbl[19] = '{2'b01, 2'b01, 2'b00, 2'b00};
    tbl[20] = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int i = 21; i < 24; i++) tbl[i] = '{2'b01, 2'b11, 2'b00, 2'b00};
    tbl[24] = '{2'b01, 2'b01, 2'b00, 2'b10};
    tbl[25] = '{2'b01, 2'b01, 2'b00, 2'b00};

    model_clear();
    #2;
    chk("reset_state", 2'b00, 2'b00, 2'b00);
    do_reset(2'b00);
    for (int i = 0; i < 20; i++) begin
      cyc(2'b00);
      chk("idle_after_reset", 2'b00, 2'b00, 2'b00);
    end

    for (int i = 0; i < 26; i++) begin
      cyc(tbl[i].in);
      chk($sformatf("table[%0d]", i), tbl[i].db, tbl[i].rise, tbl[i].fall);
    end

    // Asynchronous reset between edges while sw_db[0] is high.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 2'b00, 2'b00, 2'b00);
    do_reset(2'b00);

    // Chatter 1,0,1,0,1 then hold 1: level rises 5 edges after the last toggle.
    for (int i = 0; i < 14; i++) begin
      v = (i < 5 && (i % 2) == 1) ? 2'b00 : 2'b01;
      cyc(v);
      chk($sformatf("chatter[%0d]", i), (i >= 9) ? 2'b01 : 2'b00,
          (i == 9) ? 2'b01 : 2'b00, 2'b00);
    end

    // Both channels fall together from a debounced 11.
    do_reset(2'b00);
    for (int i = 0; i < 8; i++) begin
      cyc(2'b11);
      chk($sformatf("both_rise[%0d]", i), (i >= 5) ? 2'b11 : 2'b00,
          (i == 5) ? 2'b11 : 2'b00, 2'b00);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(2'b00);
      chk($sformatf("both_fall[%0d]", i), (i >= 5) ? 2'b00 : 2'b11,
          2'b00, (i == 5) ? 2'b11 : 2'b00);
    end

    // Reset released with a switch already held high counts as a 0->1 change.
    do_reset(2'b10);
    for (int i = 0; i < 8; i++) begin
      cyc(2'b10);
      chk($sformatf("held_high[%0d]", i), (i >= 5) ? 2'b10 : 2'b00,
          (i == 5) ? 2'b10 : 2'b00, 2'b00);
    end

    // Random hold lengths around D, with occasional resets, against the model.
    do_reset(2'b00);
    n = 0;
    while (n < 3000) begin
      v   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 7);
      for (int r = 0; r < len; r++) begin
        cyc(v);
        chk("random", mdb, mrise, mfall);
        n++;
        if (n % 700 == 0) do_reset(v);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
